// File: rtl/fnd_scan_mux.sv
// Time-multiplexed FND scan driver: two BCD pages, dots, blink and
// leading-zero blanking, one registered digit per scan slot.
module fnd_scan_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100_000,
   parameter int BLINK_DIV  = 50_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_page,
   input  logic [4*NUM_DIGITS-1:0] i_digits_a,
   input  logic [4*NUM_DIGITS-1:0] i_digits_b,
   input  logic [NUM_DIGITS-1:0]   i_dot_a,
   input  logic [NUM_DIGITS-1:0]   i_dot_b,
   input  logic [NUM_DIGITS-1:0]   i_blink_mask,
   input  logic                    i_lz_blank,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic [3:0]              o_bcd,
   output logic                    o_dp,
   output logic                    o_frame
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int BW = $clog2(BLINK_DIV);

   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

   logic [PW-1:0]           r_pre;
   logic [IW-1:0]           r_idx;
   logic                    r_page;
   logic                    r_upd;
   logic [BW-1:0]           r_blk;
   logic                    r_phase;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [3:0]              r_bcd;
   logic                    r_dp;
   logic                    r_frame;

   logic                    w_tick;
   logic [IW-1:0]           w_idx_nxt;
   logic [4*NUM_DIGITS-1:0] w_digs;
   logic [NUM_DIGITS-1:0]   w_dots;
   logic [NUM_DIGITS-1:0]   w_zf;
   logic                    w_acc;
   logic [3:0]              w_val;
   logic                    w_lz;
   logic                    w_blank;

   assign w_tick    = (r_pre == PRE_MAX);
   assign w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
   assign w_digs    = r_page ? i_digits_b : i_digits_a;
   assign w_dots    = r_page ? i_dot_b : i_dot_a;
   assign w_val     = w_digs[{r_idx, 2'b00} +: 4];

   // w_zf[k]: digits k..MSD are all zero
   always_comb begin
      w_zf  = '0;
      w_acc = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_acc   = w_acc & ~|w_digs[4*k +: 4];
         w_zf[k] = w_acc;
      end
   end

   assign w_lz    = i_lz_blank && (r_idx != '0) && w_zf[r_idx];
   assign w_blank = (i_blink_mask[r_idx] && !r_phase) || w_lz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pre  <= '0;
         r_idx  <= '0;
         r_page <= 1'b0;
         r_upd  <= 1'b0;
      end else begin
         r_upd <= w_tick;
         if (w_tick) begin
            r_pre <= '0;
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == '0)
               r_page <= i_page;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blk   <= '0;
         r_phase <= 1'b1;
      end else if (r_blk == BLK_MAX) begin
         r_blk   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_blk <= r_blk + 1'b1;
      end
   end

   // Outputs refresh one cycle after the index moves, then hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_an    <= '1;
         r_bcd   <= 4'hF;
         r_dp    <= 1'b0;
         r_frame <= 1'b0;
      end else if (r_upd) begin
         r_an    <= ~(NUM_DIGITS'(1) << r_idx);
         r_bcd   <= w_blank ? 4'hF : w_val;
         r_dp    <= w_blank ? 1'b0 : w_dots[r_idx];
         r_frame <= (r_idx == '0);
      end else begin
         r_frame <= 1'b0;
      end
   end

   assign o_an    = r_an;
   assign o_bcd   = r_bcd;
   assign o_dp    = r_dp;
   assign o_frame = r_frame;

endmodule

// File: tb/tb_fnd_scan_mux.sv
// Bench for fnd_scan_mux: cycle-arithmetic display model compared every
// cycle, plus directed literal checks of the scan sequence.
module tb_fnd_scan_mux;

   localparam int ND = 4;
   localparam int S  = 4;
   localparam int BD = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_page = 1'b0;
   logic [15:0]   i_digits_a = '0;
   logic [15:0]   i_digits_b = '0;
   logic [3:0]    i_dot_a = '0;
   logic [3:0]    i_dot_b = '0;
   logic [3:0]    i_blink_mask = '0;
   logic          i_lz_blank = 1'b0;
   logic [3:0]    o_an;
   logic [3:0]    o_bcd;
   logic          o_dp;
   logic          o_frame;

   int ncmp = 0;
   int nfail = 0;

   fnd_scan_mux #(
      .NUM_DIGITS(ND),
      .SCAN_DIV  (S),
      .BLINK_DIV (BD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_page      (i_page),
      .i_digits_a  (i_digits_a),
      .i_digits_b  (i_digits_b),
      .i_dot_a     (i_dot_a),
      .i_dot_b     (i_dot_b),
      .i_blink_mask(i_blink_mask),
      .i_lz_blank  (i_lz_blank),
      .o_an        (o_an),
      .o_bcd       (o_bcd),
      .o_dp        (o_dp),
      .o_frame     (o_frame)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] bcd;
      logic       dp;
      logic       fr;
   } exp_t;

   int   n;
   logic m_page;
   exp_t m;

   // Edge u (u = n+1) since release refreshes slot (u-1)/S mod ND when
   // u-1 is a multiple of S; blink phase visible when (u-1)/BD is even.
   function automatic exp_t model(int e);
      exp_t r;
      int idx;
      bit vis;
      bit lz;
      logic [15:0] dg;
      idx = (e / S) % ND;
      vis = ((e / BD) % 2) == 0;
      dg  = m_page ? i_digits_b : i_digits_a;
      lz  = i_lz_blank && idx != 0;
      for (int j = idx; j < ND; j++)
         if (dg[4*j +: 4] != 4'd0) lz = 1'b0;
      r.an      = 4'hF;
      r.an[idx] = 1'b0;
      r.fr      = (idx == 0);
      if ((i_blink_mask[idx] && !vis) || lz) begin
         r.bcd = 4'hF;
         r.dp  = 1'b0;
      end else begin
         r.bcd = dg[4*idx +: 4];
         r.dp  = m_page ? i_dot_b[idx] : i_dot_a[idx];
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         n      <= 0;
         m_page <= 1'b0;
         m      <= '{an: 4'hF, bcd: 4'hF, dp: 1'b0, fr: 1'b0};
      end else begin
         n <= n + 1;
         if ((n + 1) % (S * ND) == 0)
            m_page <= i_page;
         if (n + 1 > S && n % S == 0)
            m <= model(n);
         else
            m.fr <= 1'b0;
      end
   end

   always @(negedge clk) begin
      ncmp++;
      if ({o_an, o_bcd, o_dp, o_frame} !== m) begin
         nfail++;
         $display("FAIL model n=%0d: got an=%h bcd=%h dp=%b fr=%b, want an=%h bcd=%h dp=%b fr=%b",
                  n, o_an, o_bcd, o_dp, o_frame, m.an, m.bcd, m.dp, m.fr);
      end
   end

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic goto(int k);
      int g = 0;
      while (n < k && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (n != k) begin
         nfail++;
         $display("FAIL goto %0d: reached %0d", k, n);
      end
   endtask

   task automatic at(int k, logic [3:0] an, logic [3:0] bcd);
      goto(k);
      chk($sformatf("an@%0d", k), {4'h0, o_an}, {4'h0, an});
      chk($sformatf("bcd@%0d", k), {4'h0, o_bcd}, {4'h0, bcd});
   endtask

   task automatic dp_at(int k, logic dp);
      goto(k);
      chk($sformatf("dp@%0d", k), {7'h0, o_dp}, {7'h0, dp});
   endtask

   task automatic hit_reset();
      #2 rst = 1'b0;
      #1;
      chk("rst_an", {4'h0, o_an}, 8'h0F);
      chk("rst_bcd", {4'h0, o_bcd}, 8'h0F);
      chk("rst_dp", {7'h0, o_dp}, 8'h00);
      chk("rst_fr", {7'h0, o_frame}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      // basic scan of page A
      @(negedge clk);
      i_digits_a = 16'h1234;
      i_digits_b = 16'h5678;
      hit_reset();
      at(4, 4'hF, 4'hF);
      at(5, 4'hD, 4'h3);
      at(17, 4'hE, 4'h4);
      chk("frame@17", {7'h0, o_frame}, 8'h01);
      goto(18);
      chk("frame@18", {7'h0, o_frame}, 8'h00);
      at(21, 4'hD, 4'h3);
      at(25, 4'hB, 4'h2);
      at(29, 4'h7, 4'h1);

      // page switch requested mid-frame
      hit_reset();
      at(9, 4'hB, 4'h2);
      i_page = 1'b1;
      at(13, 4'h7, 4'h1);
      at(17, 4'hE, 4'h8);
      at(21, 4'hD, 4'h7);
      at(25, 4'hB, 4'h6);
      at(29, 4'h7, 4'h5);

      // reset mid-frame at idx 3, restart on page A
      hit_reset();
      at(5, 4'hD, 4'h3);
      at(13, 4'h7, 4'h1);
      at(17, 4'hE, 4'h8);
      i_page = 1'b0;

      // leading-zero blanking
      i_lz_blank = 1'b1;
      i_digits_a = 16'h0007;
      hit_reset();
      at(17, 4'hE, 4'h7);
      at(21, 4'hD, 4'hF);
      at(25, 4'hB, 4'hF);
      at(29, 4'h7, 4'hF);
      i_digits_a = 16'h0000;
      at(33, 4'hE, 4'h0);
      at(37, 4'hD, 4'hF);
      at(45, 4'h7, 4'hF);
      i_digits_a = 16'h0100;
      at(49, 4'hE, 4'h0);
      at(53, 4'hD, 4'h0);
      at(57, 4'hB, 4'h1);
      at(61, 4'h7, 4'hF);
      i_lz_blank = 1'b0;

      // blink on digit 0
      i_digits_a   = 16'h1234;
      i_blink_mask = 4'b0001;
      hit_reset();
      at(17, 4'hE, 4'hF);
      at(21, 4'hD, 4'h3);
      at(33, 4'hE, 4'h4);
      at(49, 4'hE, 4'hF);

      // dots, then dot suppressed by blink
      i_blink_mask = 4'b0000;
      i_dot_a      = 4'b0100;
      hit_reset();
      dp_at(17, 1'b0);
      dp_at(25, 1'b1);
      dp_at(29, 1'b0);
      i_blink_mask = 4'b0100;
      dp_at(41, 1'b1);
      at(57, 4'hB, 4'hF);
      dp_at(57, 1'b0);
      dp_at(73, 1'b1);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
      $finish;
   end

endmodule
